// File: rtl/operand_feeder.sv
// Operand feeder: streams N stored (x, theta) operand pairs per frame
// to a downstream stage over independent strobe/ack channels.
module operand_feeder #(
    parameter int N = 3,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_we,
    input  logic         load_sel,
    input  logic [1:0]   load_addr,
    input  logic [W-1:0] load_data,
    input  logic         start,
    input  logic         next_req,
    output logic [W-1:0] output_x,
    output logic [W-1:0] output_theta,
    output logic         output_x_stb,
    output logic         output_theta_stb,
    input  logic         output_x_ack,
    input  logic         output_theta_ack,
    output logic         busy,
    output logic         done,
    output logic [7:0]   frame_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESENT   = 2'd1,
        WAIT_NEXT = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [1:0] LAST = 2'(N - 1);

    state_t       state;
    state_t       state_nx;
    logic [1:0]   idx;
    logic [1:0]   idx_nx;
    logic         pending;
    logic         x_left;
    logic         th_left;
    logic         pair_done;
    logic         advance;
    logic         mem_we;

    logic [W-1:0] x_mem  [N];
    logic [W-1:0] th_mem [N];

    assign idx_nx    = idx + 2'd1;
    assign x_left    = output_x_stb & ~output_x_ack;
    assign th_left   = output_theta_stb & ~output_theta_ack;
    assign pair_done = ~x_left & ~th_left;
    assign advance   = pending | next_req;
    assign mem_we    = load_we && (state == IDLE) && (load_addr <= LAST);

    // Operand store: writable only while idle, no reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (load_sel)
                th_mem[load_addr] <= load_data;
            else
                x_mem[load_addr] <= load_data;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (start) state_nx = PRESENT;
            PRESENT:   if (pair_done)
                           state_nx = (idx == LAST) ? DONE : WAIT_NEXT;
            WAIT_NEXT: if (advance) state_nx = PRESENT;
            DONE:      state_nx = IDLE;
        endcase
    end

    // Datapath: operand registers, strobes, index, pending flag, counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx              <= 2'd0;
            pending          <= 1'b0;
            output_x         <= '0;
            output_theta     <= '0;
            output_x_stb     <= 1'b0;
            output_theta_stb <= 1'b0;
            frame_cnt        <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx              <= 2'd0;
                        output_x         <= x_mem[0];
                        output_theta     <= th_mem[0];
                        output_x_stb     <= 1'b1;
                        output_theta_stb <= 1'b1;
                        pending          <= 1'b0;
                    end
                end
                PRESENT: begin
                    if (output_x_ack)     output_x_stb     <= 1'b0;
                    if (output_theta_ack) output_theta_stb <= 1'b0;
                    if (next_req)         pending          <= 1'b1;
                end
                WAIT_NEXT: begin
                    if (advance) begin
                        idx              <= idx_nx;
                        output_x         <= x_mem[idx_nx];
                        output_theta     <= th_mem[idx_nx];
                        output_x_stb     <= 1'b1;
                        output_theta_stb <= 1'b1;
                        pending          <= 1'b0;
                    end
                end
                DONE: begin
                    frame_cnt <= frame_cnt + 8'd1;
                    pending   <= 1'b0;
                end
            endcase
        end
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

endmodule
